ntt_wrapper: RTL and testbench
==============================

// Module: ntt_wrapper
// PURPOSE
//  Kyber (q=3329, n=256) forward/inverse NTT engine wrapped behind a single run/done handshake.
//  Takes a full 256-coefficient polynomial in parallel and returns the transformed polynomial in parallel.
//  Sits between the KEM polynomial datapath (TYPES_KEM) and the correlated-random/KEM control FSM.
// PARAMETERS
//  Q        3329  Kyber modulus
//  N        256   coefficients per polynomial
//  LOGN_L   7     NTT layers (incomplete Kyber NTT, len 128..2)
//  NINV     3303  128^-1 mod Q, INTT final scale
// PORTS
//  clk_i      in   1     clock, all logic rising-edge
//  rst_n_i    in   1     reset, asynchronous, active-low
//  run_i      in   1     start pulse; sampled only in IDLE
//  poly_a_i   in   poly_t (256x12)  operand A, coeffs in [0,Q)
//  poly_b_i   in   poly_t (256x12)  operand B, coeffs in [0,Q)
//  mode_i     in   ntt_mode_t (2b)  NTT_a=0, NTT_b=1, INTT_a=2, INTT_b=3
//  poly_c_o   out  poly_t (256x12)  result, coeffs in [0,Q)
//  done_o     out  1     one-cycle completion pulse
// BEHAVIOUR
//  - Reset: FSM->IDLE, poly_c_o=0, done_o=0, working array cleared; reset mid-operation aborts, no done.
//  - IDLE: on run_i=1 latch mode_i and selected operand (a for *_a, b for *_b) into 256x12 register array; ->CALC.
//  - run_i while not IDLE ignored; inputs need only be valid in the run cycle.
//  - CALC: one butterfly/cycle, 7 layers x 128 = 896 cycles; counters len(128..2), start, j, zeta index k.
//  - Forward (CT, k=1..127 up): t=zeta[k]*a[j+len] mod Q; a[j+len]=a[j]-t; a[j]=a[j]+t (mod Q).
//  - Inverse (GS, k=127..1 down, len 2..128): t=a[j]; a[j]=t+a[j+len]; a[j+len]=zeta[k]*(a[j+len]-t) mod Q.
//  - zeta[k]=17^brv7(k) mod Q, plain (non-Montgomery) domain, 128x12 ROM.
//  - Modmul: 12x12 product, Barrett reduction fully to [0,Q); add/sub conditionally corrected; no lazy reduction.
//  - Inverse only: SCALE state, 128 cycles, 2 coeffs/cycle multiplied by NINV; INTT(NTT(x))==x exactly.
//  - Output order = Kyber reference C ntt()/invntt() order (pairs = deg-1 residues), fully reduced.
//  - DONE: copy array to poly_c_o, done_o=1 for exactly one cycle, ->IDLE. poly_c_o holds until next completion.
//  - Latency (run cycle = 0): forward done_o at cycle 897; inverse at cycle 1025.
// CONFIGURATION
//  - NTT_INTT_EN defined: INTT_a/INTT_b implemented as above.
//  - Not defined: GS datapath, SCALE state and NINV removed; INTT_* modes skip CALC, done_o pulses at cycle 2,
//    poly_c_o unchanged.
// STRUCTURE
//  - TYPES_KEM package: Q, N, coef_t (logic[11:0]), poly_t (coef_t [0:255]), ntt_mode_t enum, zeta ROM function/table.
//  - One sub-module: ntt_butterfly (combinational CT/GS select, Barrett modmul, mod add/sub).
//  - Wrapper holds FSM, address counters, register array, zeta ROM.
// TESTING
//  - Reset: rst_n_i=0 -> poly_c_o=0, done_o=0; hold 2 cycles, release, no done without run.
//  - NTT_a delta: a[0]=1 else 0 -> c[2i]=1, c[2i+1]=0 all i; done_o at cycle 897, single-cycle.
//  - NTT_b vector: b = Kyber test vector (random in [0,Q)) -> matches reference C ntt()+full reduce; poly_a_i ignored.
//  - Roundtrip: NTT_a(x) then INTT_a(result), x random -> poly_c_o==x; INTT done at cycle 1025 (NTT_INTT_EN).
//  - run_i pulsed mid-CALC with different mode/operand -> ignored, result and latency unchanged.
//  - rst_n_i asserted at cycle 400 of NTT -> immediate IDLE, poly_c_o=0, no done; next run completes normally.

Source files
------------

// File: rtl/TYPES_KEM.sv
// Shared Kyber NTT types, constants, fully-reducing modular helpers and the plain-domain zeta table.
// NTT_INTT_EN adds the inverse-transform scale constant NINV.
package TYPES_KEM;
    localparam int Q      = 3329;
    localparam int N      = 256;
    localparam int LOGN_L = 7;
`ifdef NTT_INTT_EN
    localparam int NINV   = 3303;
`endif
    // floor(2^24/Q): the quotient estimate is at most one short for any 12x12 product
    localparam int BARRETT_M = 5039;

    typedef logic [11:0] coef_t;
    typedef coef_t [0:N-1] poly_t;
    typedef coef_t [0:127] zeta_tab_t;
    typedef enum logic [1:0] { NTT_a = 2'd0, NTT_b = 2'd1, INTT_a = 2'd2, INTT_b = 2'd3 } ntt_mode_t;
    typedef enum logic [1:0] { S_IDLE, S_CALC, S_SCALE, S_DONE } ntt_state_t;

    function automatic coef_t mod_mul(input coef_t a, input coef_t b);
        logic [23:0] p, r;
        logic [12:0] qh;
        p  = 24'(a) * 24'(b);
        qh = 13'((37'(p) * 37'(BARRETT_M)) >> 24);
        r  = p - 24'(qh) * 24'(Q);
        return (r >= 24'(Q)) ? coef_t'(r - 24'(Q)) : coef_t'(r);
    endfunction

    function automatic coef_t mod_add(input coef_t a, input coef_t b);
        logic [12:0] s;
        s = 13'(a) + 13'(b);
        return (s >= 13'(Q)) ? coef_t'(s - 13'(Q)) : coef_t'(s);
    endfunction

    function automatic coef_t mod_sub(input coef_t a, input coef_t b);
        return (a >= b) ? coef_t'(a - b) : coef_t'(13'(a) + 13'(Q) - 13'(b));
    endfunction

    // zeta[k] = 17^brv7(k) mod Q, evaluated at elaboration
    function automatic zeta_tab_t gen_zetas();
        zeta_tab_t pw, z;
        logic [6:0] r;
        pw[0] = 12'd1;
        for (int i = 1; i < 128; i++) pw[i] = mod_mul(pw[i-1], 12'd17);
        for (int k = 0; k < 128; k++) begin
            r    = 7'(k);
            z[k] = pw[{r[0], r[1], r[2], r[3], r[4], r[5], r[6]}];
        end
        return z;
    endfunction

    localparam zeta_tab_t ZETAS = gen_zetas();
endpackage

// File: rtl/ntt_wrapper_butterfly.sv
// Combinational Kyber butterfly: Cooley-Tukey (forward) or Gentleman-Sande (inverse, NTT_INTT_EN only).
// All outputs fully reduced to [0,Q).
module ntt_butterfly
    import TYPES_KEM::*;
(
    input  logic  inv_i,
    input  coef_t u_i,
    input  coef_t v_i,
    input  coef_t zeta_i,
    output coef_t x_o,
    output coef_t y_o
);
    coef_t mul_in, prod;

`ifdef NTT_INTT_EN
    always_comb begin
        mul_in = inv_i ? mod_sub(v_i, u_i) : v_i;
        prod   = mod_mul(zeta_i, mul_in);
        x_o    = mod_add(u_i, inv_i ? v_i : prod);
        y_o    = inv_i ? prod : mod_sub(u_i, prod);
    end
`else
    logic unused_inv;
    assign unused_inv = inv_i;

    always_comb begin
        mul_in = v_i;
        prod   = mod_mul(zeta_i, mul_in);
        x_o    = mod_add(u_i, prod);
        y_o    = mod_sub(u_i, prod);
    end
`endif
endmodule

// File: rtl/ntt_wrapper.sv
// Kyber 256-point NTT/INTT engine behind a run/done handshake; one butterfly per cycle over a register array.
// NTT_INTT_EN enables INTT modes (GS butterflies + NINV scale); otherwise INTT modes just pulse done.
module ntt_wrapper
    import TYPES_KEM::*;
(
    input  logic      clk_i,
    input  logic      rst_n_i,
    input  logic      run_i,
    input  poly_t     poly_a_i,
    input  poly_t     poly_b_i,
    input  ntt_mode_t mode_i,
    output poly_t     poly_c_o,
    output logic      done_o
);
    ntt_state_t  state_q, state_d;
    poly_t       arr_q, arr_d, poly_c_q, poly_c_d;
    logic        inv_q, inv_d;
    logic [2:0]  layer_q, layer_d;
    logic [6:0]  bfly_q, bfly_d;

    logic        skip, last_bfly;
    logic [2:0]  shamt;
    logic [7:0]  len, j, jh;
    logic [6:0]  grp, zidx;
    coef_t       zeta, bf_x, bf_y;
`ifdef NTT_INTT_EN
    coef_t       s0, s1;
`endif

`ifdef NTT_INTT_EN
    assign skip = 1'b0;
`else
    assign skip = inv_q;
`endif
    assign last_bfly = (layer_q == 3'(LOGN_L - 1)) && (bfly_q == 7'd127);

    // Butterfly index b within a layer maps to j = group*2*len + b%len, with len = 2^shamt
    always_comb begin
        shamt = inv_q ? layer_q + 3'd1 : 3'd7 - layer_q;
        len   = 8'd1 << shamt;
        grp   = bfly_q >> shamt;
        j     = ({1'b0, grp} << ({1'b0, shamt} + 4'd1)) | ({1'b0, bfly_q} & (len - 8'd1));
        jh    = j + len;
        zidx  = inv_q ? 7'((9'd256 >> shamt) - 9'd1 - {2'b0, grp})
                      : 7'((9'd128 >> shamt) + {2'b0, grp});
        zeta  = ZETAS[zidx];
    end

    ntt_butterfly u_bf (
        .inv_i  (inv_q),
        .u_i    (arr_q[j]),
        .v_i    (arr_q[jh]),
        .zeta_i (zeta),
        .x_o    (bf_x),
        .y_o    (bf_y)
    );

`ifdef NTT_INTT_EN
    assign s0 = mod_mul(arr_q[{bfly_q, 1'b0}], 12'(NINV));
    assign s1 = mod_mul(arr_q[{bfly_q, 1'b1}], 12'(NINV));
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (run_i) state_d = S_CALC;
            S_CALC: begin
                if (skip)           state_d = S_DONE;
`ifdef NTT_INTT_EN
                else if (last_bfly) state_d = inv_q ? S_SCALE : S_DONE;
            end
            S_SCALE: if (bfly_q == 7'd127) state_d = S_DONE;
`else
                else if (last_bfly) state_d = S_DONE;
            end
            S_SCALE: state_d = S_IDLE;
`endif
            S_DONE:  state_d = S_IDLE;
        endcase
    end

    assign done_o   = (state_q == S_DONE);
    assign poly_c_o = poly_c_q;

    always_comb begin
        arr_d   = arr_q;
        inv_d   = inv_q;
        layer_d = layer_q;
        bfly_d  = bfly_q;
        unique case (state_q)
            S_IDLE: if (run_i) begin
                inv_d   = mode_i[1];
                arr_d   = mode_i[0] ? poly_b_i : poly_a_i;
                layer_d = 3'd0;
                bfly_d  = 7'd0;
            end
            S_CALC: if (!skip) begin
                arr_d[j]  = bf_x;
                arr_d[jh] = bf_y;
                bfly_d    = bfly_q + 7'd1;
                if (bfly_q == 7'd127) layer_d = layer_q + 3'd1;
            end
`ifdef NTT_INTT_EN
            S_SCALE: begin
                arr_d[{bfly_q, 1'b0}] = s0;
                arr_d[{bfly_q, 1'b1}] = s1;
                bfly_d = bfly_q + 7'd1;
            end
`else
            S_SCALE: ;
`endif
            S_DONE: ;
        endcase
        // Result is captured on entry to DONE so it is valid alongside done_o
        poly_c_d = (state_d == S_DONE && state_q != S_DONE && !skip) ? arr_d : poly_c_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            arr_q    <= '0;
            poly_c_q <= '0;
            inv_q    <= 1'b0;
            layer_q  <= 3'd0;
            bfly_q   <= 7'd0;
        end else begin
            arr_q    <= arr_d;
            poly_c_q <= poly_c_d;
            inv_q    <= inv_d;
            layer_q  <= layer_d;
            bfly_q   <= bfly_d;
        end
    end
endmodule

// File: tb/tb_ntt_wrapper.sv
// Bench for ntt_wrapper: reference-style NTT/INTT model, per-cycle compare of done_o/poly_c_o, directed runs.
module tb_ntt_wrapper;
    import TYPES_KEM::*;

    logic      clk = 1'b0, rst_n = 1'b0, run = 1'b0, done;
    poly_t     pa = '0, pb = '0, pc;
    ntt_mode_t mode = NTT_a;

    ntt_wrapper dut (
        .clk_i(clk), .rst_n_i(rst_n), .run_i(run), .poly_a_i(pa), .poly_b_i(pb),
        .mode_i(mode), .poly_c_o(pc), .done_o(done)
    );

    always #5 clk = ~clk;

`ifdef NTT_INTT_EN
    localparam bit INV_EN  = 1'b1;
    localparam int LAT_INV = 1025;
`else
    localparam bit INV_EN  = 1'b0;
    localparam int LAT_INV = 2;
`endif
    localparam int LAT_FWD = 897;

    int    checks = 0, errors = 0;
    int    zt[128];
    poly_t exp_c = '0, next_c = '0;
    bit    active = 1'b0;
    int    since = 0, lat = 0, fi = 0;

    function automatic poly_t rand_poly();
        poly_t p;
        for (int i = 0; i < 256; i++) p[i] = 12'($urandom_range(Q - 1));
        return p;
    endfunction

    function automatic poly_t model_ntt(input poly_t x);
        int r[256];
        int k, t, z, j;
        poly_t y;
        k = 1;
        for (int i = 0; i < 256; i++) r[i] = int'(x[i]);
        for (int len = 128; len >= 2; len = len / 2)
            for (int st = 0; st < 256; st = st + 2 * len) begin
                z = zt[k]; k++;
                for (j = st; j < st + len; j++) begin
                    t = (z * r[j+len]) % Q;
                    r[j+len] = (r[j] - t + Q) % Q;
                    r[j] = (r[j] + t) % Q;
                end
            end
        for (int i = 0; i < 256; i++) y[i] = 12'(r[i]);
        return y;
    endfunction

    function automatic poly_t model_intt(input poly_t x);
        int r[256];
        int k, t, z, j;
        poly_t y;
        k = 127;
        for (int i = 0; i < 256; i++) r[i] = int'(x[i]);
        for (int len = 2; len <= 128; len = len * 2)
            for (int st = 0; st < 256; st = st + 2 * len) begin
                z = zt[k]; k--;
                for (j = st; j < st + len; j++) begin
                    t = r[j];
                    r[j] = (t + r[j+len]) % Q;
                    r[j+len] = (z * ((r[j+len] - t + Q) % Q)) % Q;
                end
            end
        for (int i = 0; i < 256; i++) y[i] = 12'((r[i] * 3303) % Q);
        return y;
    endfunction

    function automatic int pairs_are(input poly_t p, input int ev, input int od);
        for (int i = 0; i < 128; i++)
            if (int'(p[2*i]) != ev || int'(p[2*i+1]) != od) return 0;
        return 1;
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    // Per-cycle comparison of both outputs against the expected state
    always @(negedge clk) begin
        checks++;
        if (active) begin
            if (done !== (since == lat)) begin
                errors++;
                $display("FAIL done_o at run cycle %0d: got %b want %b", since, done, since == lat);
            end
            if (since == lat) begin
                exp_c  = next_c;
                active = 1'b0;
            end
            since++;
        end else if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_o idle at %0t: got %b want 0", $time, done);
        end
        checks++;
        if (pc !== exp_c) begin
            errors++;
            fi = 0;
            for (int i = 255; i >= 0; i--) if (pc[i] !== exp_c[i]) fi = i;
            $display("FAIL poly_c_o at %0t: c[%0d] got %0d want %0d", $time, fi, pc[fi], exp_c[fi]);
        end
    end

    task automatic run_op(input ntt_mode_t m, input poly_t a, input poly_t b, input poly_t expect_c,
                          input int l, input int pulse_at, input int rst_at);
        @(posedge clk); #1;
        run = 1'b1; mode = m; pa = a; pb = b;
        next_c = expect_c; lat = l; since = 0; active = 1'b1;
        @(posedge clk); #1;
        run = 1'b0; mode = ntt_mode_t'(2'($urandom_range(3))); pa = rand_poly(); pb = rand_poly();
        for (int c = 1; c <= l; c++) begin
            if (c == pulse_at) begin
                run = 1'b1; mode = INTT_b; pb = rand_poly();
            end
            if (c == rst_at) begin
                rst_n = 1'b0; active = 1'b0; exp_c = '0;
            end
            if (rst_at > 0 && c == rst_at + 2) rst_n = 1'b1;
            @(posedge clk); #1;
            run = 1'b0;
        end
    endtask

    initial begin
        int pw[128];
        int br;
        poly_t d, x, y, z;

        pw[0] = 1;
        for (int i = 1; i < 128; i++) pw[i] = (pw[i-1] * 17) % Q;
        for (int k = 0; k < 128; k++) begin
            br = 0;
            for (int bt = 0; bt < 7; bt++) if (((k >> bt) & 1) == 1) br = br | (1 << (6 - bt));
            zt[k] = pw[br];
        end

        chk("model_zeta1", zt[1], 1729);
        chk("model_zeta2", zt[2], 2580);
        chk("model_zeta3", zt[3], 3289);
        d = '0; d[0] = 12'd1;
        chk("model_ntt_delta", pairs_are(model_ntt(d), 1, 0), 1);
        d = '0; d[1] = 12'd1;
        chk("model_ntt_x", pairs_are(model_ntt(d), 0, 1), 1);
        x = rand_poly();
        chk("model_roundtrip", int'(model_intt(model_ntt(x)) == x), 1);

        // Reset held two cycles, then idle with no done
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        d = '0; d[0] = 12'd1;
        run_op(NTT_a, d, rand_poly(), model_ntt(d), LAT_FWD, 0, 0);
        chk("ntt_delta_literal", pairs_are(pc, 1, 0), 1);

        y = rand_poly();
        run_op(NTT_b, rand_poly(), y, model_ntt(y), LAT_FWD, 0, 0);

        d = '0; d[1] = 12'd1;
        run_op(NTT_a, d, rand_poly(), model_ntt(d), LAT_FWD, 0, 0);
        chk("ntt_x_literal", pairs_are(pc, 0, 1), 1);

        for (int i = 0; i < 256; i++) d[i] = 12'(Q - 1);
        run_op(NTT_a, d, rand_poly(), model_ntt(d), LAT_FWD, 0, 0);

        x = rand_poly();
        y = model_ntt(x);
        run_op(NTT_a, x, rand_poly(), y, LAT_FWD, 0, 0);
        run_op(INTT_a, y, rand_poly(), INV_EN ? x : y, LAT_INV, 0, 0);

        z = INV_EN ? model_intt(d) : exp_c;
        run_op(INTT_b, rand_poly(), d, z, LAT_INV, 950, 0);

        // Stray run mid-CALC must not disturb result or latency
        x = rand_poly();
        run_op(NTT_a, x, rand_poly(), model_ntt(x), LAT_FWD, 300, 0);

        // Reset at cycle 400 aborts; the next run completes normally
        x = rand_poly();
        run_op(NTT_a, x, rand_poly(), model_ntt(x), LAT_FWD, 0, 400);
        y = rand_poly();
        run_op(NTT_b, rand_poly(), y, model_ntt(y), LAT_FWD, 0, 0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
